// File: rtl/ce_arb_pkg.sv
// ---------------------------------------------------------------------------
// ce_arb_pkg
// Shared types, constants and helpers for the copy-engine TX packet arbiter.
//   t_arb_state       : arbiter FSM states (IDLE, XFER)
//   CE_ARB_SKID_DEPTH : number of entries in the output skid buffer
//   rr_pick()         : round-robin search returning a one-hot grant
// ---------------------------------------------------------------------------
package ce_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } t_arb_state;

  localparam int CE_ARB_SKID_DEPTH = 2;

  // Returns a one-hot vector selecting the first set bit of valid[num-1:0],
  // searching upward from index ptr and wrapping at num. Sized for up to 8
  // requesters; the caller truncates to its own width. ptr must be < num.
  function automatic logic [7:0] rr_pick(input logic [7:0] valid,
                                         input logic [2:0] ptr,
                                         input logic [3:0] num);
    logic [7:0] pick;
    logic       found;
    logic [3:0] idx;
    pick  = 8'd0;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = 4'(ptr) + 4'(k);
      // ptr < num and k < num, so one subtraction is enough to wrap
      if (idx >= num) begin
        idx = idx - num;
      end else begin
        idx = idx;
      end
      if (!found && (4'(k) < num) && valid[idx[2:0]]) begin
        pick[idx[2:0]] = 1'b1;
        found          = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ce_tx_pkt_arbiter_skid.sv
// ---------------------------------------------------------------------------
// ce_axis_skid_buf
// Two-entry registered AXI-Stream buffer. The upstream ready is a register
// that is low only when both entries are occupied, so a continuous stream
// passes at one beat per cycle while the sink is ready.
// Ports:
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   s_valid_i / s_ready_o  : upstream handshake
//   s_data_i/keep/user/last: upstream beat
//   m_valid_o / m_ready_i  : downstream handshake
//   m_data_o/keep/user/last: head entry
//   count_o                : number of occupied entries (0..2)
// ---------------------------------------------------------------------------
module ce_axis_skid_buf
  import ce_arb_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int KEEP_W = DATA_W / 8,
  parameter int USER_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic [KEEP_W-1:0] s_keep_i,
  input  logic [USER_W-1:0] s_user_i,
  input  logic              s_last_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic [KEEP_W-1:0] m_keep_o,
  output logic [USER_W-1:0] m_user_o,
  output logic              m_last_o,
  output logic [1:0]        count_o
);

  localparam int W = DATA_W + KEEP_W + USER_W + 1;

  logic [W-1:0] head_q, head_d, tail_q, tail_d, in_s;
  logic [1:0]   cnt_q, cnt_d;
  logic         rdy_q, rdy_d;
  logic         push_s, pop_s;

  assign in_s   = {s_data_i, s_keep_i, s_user_i, s_last_i};
  assign push_s = s_valid_i & rdy_q;
  assign pop_s  = (cnt_q != 2'd0) & m_ready_i;

  // Next-state for the two entries and the occupancy count.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (push_s) begin
          head_d = in_s;
          cnt_d  = 2'd1;
        end else begin
          cnt_d = 2'd0;
        end
      end
      2'd1: begin
        if (push_s && pop_s) begin
          head_d = in_s;
        end else if (push_s) begin
          tail_d = in_s;
          cnt_d  = 2'd2;
        end else if (pop_s) begin
          cnt_d = 2'd0;
        end else begin
          cnt_d = 2'd1;
        end
      end
      2'd2: begin
        // ready is low at count 2, so only a pop can happen here
        if (pop_s) begin
          head_d = tail_q;
          cnt_d  = 2'd1;
        end else begin
          cnt_d = 2'd2;
        end
      end
      default: begin
        cnt_d = 2'd0;
      end
    endcase
    rdy_d = (cnt_d != 2'(CE_ARB_SKID_DEPTH));
  end

  // Entry, count and ready registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
      rdy_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      rdy_q  <= rdy_d;
    end
  end

  assign s_ready_o = rdy_q;
  assign m_valid_o = (cnt_q != 2'd0);
  assign count_o   = cnt_q;
  assign {m_data_o, m_keep_o, m_user_o, m_last_o} = head_q;

endmodule

// File: rtl/ce_tx_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// ce_tx_pkt_arbiter
// Packet-atomic round-robin arbiter sharing one PCIe SS TX AXI-Stream port
// between NUM_REQ copy-engine sources. A grant is held from the first beat
// to tlast; the master side is driven from a 2-entry skid buffer.
// Ports:
//   fim_clk, fim_rst_n        : clock, synchronous active-low reset
//   s_tvalid/s_tready/s_tlast : per-requester handshake and end of packet
//   s_tdata/s_tkeep/s_tuser   : flattened, requester i at [i*W +: W]
//   m_t*                      : master AXI-Stream towards the PCIe SS
//   grant                     : one-hot current owner, 0 when idle
//   busy                      : packet in progress or skid buffer non-empty
// ---------------------------------------------------------------------------
module ce_tx_pkt_arbiter
  import ce_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 512,
  parameter int USER_W  = 10,
  parameter int KEEP_W  = DATA_W / 8
) (
  input  logic                      fim_clk,
  input  logic                      fim_rst_n,
  input  logic [NUM_REQ-1:0]        s_tvalid,
  output logic [NUM_REQ-1:0]        s_tready,
  input  logic [NUM_REQ*DATA_W-1:0] s_tdata,
  input  logic [NUM_REQ*KEEP_W-1:0] s_tkeep,
  input  logic [NUM_REQ-1:0]        s_tlast,
  input  logic [NUM_REQ*USER_W-1:0] s_tuser,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [DATA_W-1:0]         m_tdata,
  output logic [KEEP_W-1:0]         m_tkeep,
  output logic                      m_tlast,
  output logic [USER_W-1:0]         m_tuser,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy
);

  t_arb_state         state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [2:0]         rr_ptr_q;

  logic [DATA_W-1:0]  sel_data_s;
  logic [KEEP_W-1:0]  sel_keep_s;
  logic [USER_W-1:0]  sel_user_s;
  logic               sel_last_s;
  logic               sel_valid_s;
  logic [2:0]         owner_s;
  logic [2:0]         next_ptr_s;
  logic               skid_ready_s;
  logic [1:0]         skid_cnt_s;
  logic               push_s;
  logic               pkt_end_s;
  logic [7:0]         valid8_s;
  logic [NUM_REQ-1:0] pick_idle_s;
  logic [NUM_REQ-1:0] pick_end_s;

  // Owner beat mux driven by the one-hot grant.
  always_comb begin
    sel_data_s  = '0;
    sel_keep_s  = '0;
    sel_user_s  = '0;
    sel_last_s  = 1'b0;
    sel_valid_s = 1'b0;
    owner_s     = 3'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        sel_data_s  = s_tdata[i*DATA_W +: DATA_W];
        sel_keep_s  = s_tkeep[i*KEEP_W +: KEEP_W];
        sel_user_s  = s_tuser[i*USER_W +: USER_W];
        sel_last_s  = s_tlast[i];
        sel_valid_s = s_tvalid[i];
        owner_s     = 3'(i);
      end else begin
        owner_s = owner_s;
      end
    end
  end

  assign s_tready   = (state_q == XFER && skid_ready_s) ? grant_q : '0;
  assign push_s     = |(s_tvalid & s_tready);
  assign pkt_end_s  = push_s & sel_last_s;
  assign next_ptr_s = (owner_s == 3'(NUM_REQ - 1)) ? 3'd0 : owner_s + 3'd1;
  assign valid8_s   = 8'(s_tvalid);
  // At packet end the search starts after the owner, so the owner is last
  assign pick_idle_s = NUM_REQ'(rr_pick(valid8_s, rr_ptr_q, 4'(NUM_REQ)));
  assign pick_end_s  = NUM_REQ'(rr_pick(valid8_s, next_ptr_s, 4'(NUM_REQ)));

  // Arbitration FSM: grant on entry from IDLE, re-arbitrate on tlast accept.
  always_ff @(posedge fim_clk) begin
    if (!fim_rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|s_tvalid) begin
            grant_q <= pick_idle_s;
            state_q <= XFER;
          end else begin
            grant_q <= '0;
          end
        end
        XFER: begin
          if (pkt_end_s) begin
            rr_ptr_q <= next_ptr_s;
            if (|s_tvalid) begin
              grant_q <= pick_end_s;
            end else begin
              grant_q <= '0;
              state_q <= IDLE;
            end
          end else begin
            grant_q <= grant_q;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  ce_axis_skid_buf #(
    .DATA_W(DATA_W),
    .KEEP_W(KEEP_W),
    .USER_W(USER_W)
  ) u_skid (
    .clk_i    (fim_clk),
    .rst_ni   (fim_rst_n),
    .s_valid_i((state_q == XFER) & sel_valid_s),
    .s_ready_o(skid_ready_s),
    .s_data_i (sel_data_s),
    .s_keep_i (sel_keep_s),
    .s_user_i (sel_user_s),
    .s_last_i (sel_last_s),
    .m_valid_o(m_tvalid),
    .m_ready_i(m_tready),
    .m_data_o (m_tdata),
    .m_keep_o (m_tkeep),
    .m_user_o (m_tuser),
    .m_last_o (m_tlast),
    .count_o  (skid_cnt_s)
  );

  assign grant = grant_q;
  assign busy  = (state_q == XFER) | (skid_cnt_s != 2'd0);

endmodule

// File: tb/tb_ce_tx_pkt_arbiter.sv
// Bench for ce_tx_pkt_arbiter: two requesters, 64-bit data. A transaction
// level model (owner index, pointer, beat queue) predicts grant, ready,
// busy and the m_* beat each cycle; a scoreboard checks per-requester order
// and packet atomicity; directed scenarios add literal expectations.
module tb_ce_tx_pkt_arbiter;
  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 64;
  localparam int KEEP_W  = 8;
  localparam int USER_W  = 10;
  localparam int BW      = DATA_W + KEEP_W + USER_W + 1;

  typedef logic [BW-1:0] beat_t;

  logic                      fim_clk = 1'b0;
  logic                      fim_rst_n;
  logic [NUM_REQ-1:0]        s_tvalid, s_tready, s_tlast;
  logic [NUM_REQ*DATA_W-1:0] s_tdata;
  logic [NUM_REQ*KEEP_W-1:0] s_tkeep;
  logic [NUM_REQ*USER_W-1:0] s_tuser;
  logic                      m_tvalid, m_tready, m_tlast, busy;
  logic [DATA_W-1:0]         m_tdata;
  logic [KEEP_W-1:0]         m_tkeep;
  logic [USER_W-1:0]         m_tuser;
  logic [NUM_REQ-1:0]        grant;

  ce_tx_pkt_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .USER_W(USER_W), .KEEP_W(KEEP_W)) dut (
    .fim_clk(fim_clk), .fim_rst_n(fim_rst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .grant(grant), .busy(busy)
  );

  always #5 fim_clk = ~fim_clk;

  beat_t q0[$], q1[$], mq[$];
  int    m_owner, m_ptr;
  bit    m_rdy;
  int    n_tests, n_fail;
  bit    chk_en, sb_en, rand_rdy;
  bit    acc0, acc1;
  int    gen_pkt[2];
  int    sb_pkt[2], sb_beat[2];
  int    sb_src, sb_beats, sb_pkts;
  int    beat_log[$], pkt_log[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [1:0] v, input int start);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(start + k) % NUM_REQ]) return (start + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic beat_t in_beat(input int r);
    return {s_tdata[r*DATA_W +: DATA_W], s_tkeep[r*KEEP_W +: KEEP_W],
            s_tuser[r*USER_W +: USER_W], s_tlast[r]};
  endfunction

  // Compare DUT against the model, log handshakes, then advance the model.
  task automatic model_step();
    logic [1:0] eg, es;
    bit         push, pop;
    beat_t      b;
    int         r;
    eg = (m_owner < 0) ? 2'b00 : 2'(1 << m_owner);
    es = (m_owner >= 0 && m_rdy) ? eg : 2'b00;
    if (chk_en) begin
      chk("grant", grant, eg);
      chk("s_tready", s_tready, es);
      chk("m_tvalid", m_tvalid, 1'(mq.size() != 0));
      chk("busy", busy, 1'(m_owner >= 0 || mq.size() != 0));
      if (mq.size() != 0) chk("m_beat", {m_tdata, m_tkeep, m_tuser, m_tlast}, mq[0]);
    end
    if (fim_rst_n && m_tvalid && m_tready) begin
      r = int'(m_tdata[63:56]);
      beat_log.push_back(r);
      if (m_tlast) pkt_log.push_back(r);
      if (sb_en) begin
        if (r > 1) begin
          chk("sb_src_range", 128'(r), 128'(0));
        end else begin
          if (sb_src >= 0) chk("sb_atomic", 128'(r), 128'(sb_src));
          chk("sb_order", {m_tdata[55:32], m_tdata[31:16]}, {24'(sb_pkt[r]), 16'(sb_beat[r])});
          sb_beats++;
          if (m_tlast) begin
            sb_pkt[r]++; sb_beat[r] = 0; sb_src = -1; sb_pkts++;
          end else begin
            sb_beat[r]++; sb_src = r;
          end
        end
      end
    end
    acc0 = s_tvalid[0] & s_tready[0];
    acc1 = s_tvalid[1] & s_tready[1];
    if (!fim_rst_n) begin
      m_owner = -1; m_ptr = 0; m_rdy = 1'b0; mq.delete();
    end else begin
      pop  = (mq.size() != 0) && m_tready;
      push = (m_owner >= 0) && m_rdy && s_tvalid[m_owner];
      b    = (m_owner >= 0) ? in_beat(m_owner) : '0;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(b);
      m_rdy = (mq.size() < 2);
      if (m_owner < 0) begin
        if (s_tvalid != 2'b00) m_owner = pick(s_tvalid, m_ptr);
      end else if (push && b[0]) begin
        m_ptr   = (m_owner + 1) % NUM_REQ;
        m_owner = (s_tvalid != 2'b00) ? pick(s_tvalid, m_ptr) : -1;
      end
    end
  endtask

  task automatic drive();
    beat_t h0, h1;
    h0 = (q0.size() != 0) ? q0[0] : '0;
    h1 = (q1.size() != 0) ? q1[0] : '0;
    s_tvalid = {1'(q1.size() != 0), 1'(q0.size() != 0)};
    {s_tdata[DATA_W +: DATA_W], s_tkeep[KEEP_W +: KEEP_W], s_tuser[USER_W +: USER_W], s_tlast[1]} = h1;
    {s_tdata[0 +: DATA_W], s_tkeep[0 +: KEEP_W], s_tuser[0 +: USER_W], s_tlast[0]} = h0;
    m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic tick();
    @(negedge fim_clk);
    model_step();
    @(posedge fim_clk);
    #1;
    if (acc0) void'(q0.pop_front());
    if (acc1) void'(q1.pop_front());
    drive();
  endtask

  // Beat encoding: [63:56] requester, [55:32] packet number, [31:16] beat.
  task automatic add_pkt(input int r, input int len);
    beat_t bt;
    for (int b = 0; b < len; b++) begin
      bt = {8'(r), 24'(gen_pkt[r]), 16'(b), 16'hC0DE ^ 16'(b * 7),
            8'(b * 3 + r + 1), 10'(gen_pkt[r] * 5 + b), 1'(b == len - 1)};
      if (r == 0) q0.push_back(bt); else q1.push_back(bt);
    end
    gen_pkt[r]++;
  endtask

  task automatic do_reset();
    fim_rst_n = 1'b0;
    q0.delete(); q1.delete();
    gen_pkt[0] = 0; gen_pkt[1] = 0;
    beat_log.delete(); pkt_log.delete();
    drive();
    tick();
    fim_rst_n = 1'b1;
    drive();
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || m_tvalid) && n < budget) begin
      tick();
      n++;
    end
    n_tests++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL %s: not drained after %0d cycles", name, n);
    end
  endtask

  int exp_src3[6] = '{0, 0, 0, 0, 1, 1};
  int total;

  initial begin
    n_tests = 0; n_fail = 0; chk_en = 1'b0; sb_en = 1'b0; rand_rdy = 1'b0;
    m_owner = -1; m_ptr = 0; m_rdy = 1'b0;
    fim_rst_n = 1'b0;
    drive();
    tick(); tick();
    chk_en = 1'b1;
    // reset state
    chk("rst_grant", grant, 2'b00);
    chk("rst_s_tready", s_tready, 2'b00);
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_m_data", {m_tdata, m_tkeep, m_tuser, m_tlast}, 83'd0);
    fim_rst_n = 1'b1;
    tick();

    // Single 3-beat packet from requester 0
    do_reset(); tick();
    add_pkt(0, 3); drive();
    tick();
    chk("s1_grant", grant, 2'b01);
    chk("s1_ready", s_tready, 2'b01);
    chk("s1_no_beat_yet", m_tvalid, 1'b0);
    tick();
    chk("s1_b0", {m_tvalid, m_tlast, m_tdata}, {1'b1, 1'b0, 64'h0000_0000_0000_C0DE});
    tick();
    chk("s1_b1", {m_tvalid, m_tlast, m_tdata}, {1'b1, 1'b0, 64'h0000_0000_0001_C0D9});
    tick();
    chk("s1_b2", {m_tvalid, m_tlast, m_tdata}, {1'b1, 1'b1, 64'h0000_0000_0002_C0D0});
    tick();
    chk("s1_empty", m_tvalid, 1'b0);

    // Both requesters continuously valid, 1-beat packets
    do_reset();
    for (int k = 0; k < 6; k++) begin add_pkt(0, 1); add_pkt(1, 1); end
    drive();
    wait_idle(200, "s2_drain");
    chk("s2_npkts", 128'(pkt_log.size()), 128'(12));
    for (int k = 0; k < 12 && k < pkt_log.size(); k++) chk("s2_rr_order", 128'(pkt_log[k]), 128'(k % 2));

    // Requester 1 arrives during requester 0's 4-beat packet
    do_reset(); tick();
    add_pkt(0, 4); drive();
    tick();
    tick();
    add_pkt(1, 2); drive();
    tick(); tick();
    chk("s3_grant_hold", grant, 2'b01);
    tick();
    chk("s3_grant_switch", grant, 2'b10);
    wait_idle(100, "s3_drain");
    chk("s3_nbeats", 128'(beat_log.size()), 128'(6));
    for (int k = 0; k < 6 && k < beat_log.size(); k++) chk("s3_no_interleave", 128'(beat_log[k]), 128'(exp_src3[k]));

    // 100 random-length packets under random m_tready
    do_reset();
    sb_en = 1'b1; sb_src = -1; sb_beats = 0; sb_pkts = 0;
    sb_pkt[0] = 0; sb_pkt[1] = 0; sb_beat[0] = 0; sb_beat[1] = 0;
    rand_rdy = 1'b1;
    total = 0;
    for (int n = 0; n < 100; n++) begin
      int len;
      len = $urandom_range(1, 16);
      add_pkt($urandom_range(0, 1), len);
      total += len;
    end
    drive();
    wait_idle(20000, "s4_drain");
    chk("s4_beats", 128'(sb_beats), 128'(total));
    chk("s4_pkts", 128'(sb_pkts), 128'(100));
    sb_en = 1'b0; rand_rdy = 1'b0; drive();

    // Reset in the middle of a packet
    do_reset(); tick();
    add_pkt(0, 8); drive();
    tick(); tick(); tick(); tick();
    fim_rst_n = 1'b0; q0.delete(); q1.delete(); drive();
    tick();
    chk("s5_m_tvalid", m_tvalid, 1'b0);
    chk("s5_grant", grant, 2'b00);
    chk("s5_s_tready", s_tready, 2'b00);
    chk("s5_busy", busy, 1'b0);
    fim_rst_n = 1'b1;
    add_pkt(1, 2); drive();
    tick();
    chk("s5_new_grant", grant, 2'b10);
    wait_idle(100, "s5_drain");

    // Lone requester 1, back-to-back 2-beat packets
    do_reset(); tick();
    for (int k = 0; k < 3; k++) add_pkt(1, 2);
    drive();
    tick();
    chk("s6_grant", grant, 2'b10);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("s6_stream", {m_tvalid, grant, m_tdata[55:32], m_tdata[31:16]},
          {1'b1, 2'b10, 24'(k / 2), 16'(k % 2)});
    end
    tick();
    chk("s6_done", m_tvalid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
